imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the instruction-memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter NOP_INST, default 32'h00000013, meaning the word returned for any fetch that is not served from memory.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port rom_ce_i, input, 1 bit: fetch enable from the core.
REQ-006 SHALL have port rom_addr_i, input, 32 bits: fetch byte address from the core.
REQ-007 SHALL have port rom_data_o, output, 32 bits: instruction word returned to the core.
REQ-008 SHALL have port ld_valid_i, input, 1 bit: load byte valid.
REQ-009 SHALL have port ld_byte_i, input, 8 bits: load byte, program image in little-endian order.
REQ-010 SHALL have port ld_last_i, input, 1 bit: marks the final image byte; qualified by ld_valid_i.
REQ-011 SHALL have port ld_ready_o, output, 1 bit: load byte accepted this cycle when both ld_valid_i and ld_ready_o are high.
REQ-012 SHALL have port core_rst_o, output, 1 bit: active-low core reset; 0 holds the core in reset.
REQ-013 SHALL have port ld_err_o, output, 1 bit: image overflow flag.
REQ-014 SHALL have port ld_words_o, output, clog2(DEPTH_WORDS)+1 bits: count of words written to memory.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, RUN and ERR; the reset state is IDLE.
REQ-016 SHALL drive ld_ready_o=1 in IDLE and LOAD, and ld_ready_o=0 in RUN and ERR.
REQ-017 SHALL drive core_rst_o=1 only in RUN.
REQ-018 SHALL drive ld_err_o=1 only in ERR.
REQ-019 SHALL transition IDLE->LOAD on the first accepted byte; on that same byte, ld_last_i=1 SHALL transition IDLE->RUN instead.
REQ-020 SHALL track each byte's position within its word with a 2-bit lane counter: the accepted byte goes into lane[cnt] of a word buffer, where lane 0 is bits 7:0, and the counter increments mod 4.
REQ-021 SHALL, on an accepted byte in lane 3, write the full buffer to mem[wptr] in the same edge, increment wptr and ld_words_o, and clear the buffer.
REQ-022 SHALL, on an accepted byte with ld_last_i=1 and lane!=3, write the partial word to mem[wptr] with the unfilled upper lanes zero, increment wptr and ld_words_o, and go to RUN.
REQ-023 SHALL, on an accepted byte with ld_last_i=1 and lane==3, perform a single write only (no extra write) and go to RUN.
REQ-024 SHALL, when a byte is accepted with wptr==DEPTH_WORDS, not write that byte and go to ERR; ERR SHALL hold until reset.
REQ-025 SHALL drive rom_data_o combinationally (zero latency), because the core captures rom_data_i on the same edge as its PC.
REQ-026 SHALL drive rom_data_o = mem[rom_addr_i[31:2]] when the state is RUN, rom_ce_i=1 and rom_addr_i[31:2] < ld_words_o; otherwise rom_data_o = NOP_INST.
REQ-027 SHALL ignore rom_addr_i[1:0].
REQ-028 SHALL ignore ld_valid_i, ld_byte_i and ld_last_i in RUN and ERR.
REQ-029 SHALL not read from or write to memory on a fetch in any state other than RUN.

Reset
REQ-030 SHALL, on rst_i=0 and at any time including mid-load, immediately set state=IDLE, lane=0, wptr=0, ld_words_o=0, word buffer=0, ld_ready_o=1, core_rst_o=0, ld_err_o=0.
REQ-031 SHALL not clear memory contents on reset; locations at or above ld_words_o are unreachable until rewritten.
REQ-032 SHALL release core_rst_o synchronously; it rises on the edge that enters RUN.

Verification
REQ-033 Load bytes 13 00 00 00 93 00 10 00 with ld_last_i on the 8th byte -> ld_words_o=2 and core_rst_o=1 after the 8th edge; fetch at address 0x4 -> rom_data_o=32'h00100093.
REQ-034 Load 6 bytes AA BB CC DD 11 22 with ld_last_i on the 6th -> mem[1]=32'h00002211 and ld_words_o=2; fetch at 0x8 -> 32'h00000013.
REQ-035 Toggle ld_valid_i with idle gaps during a load -> bytes are accepted only on handshake cycles; after RUN, further ld_valid_i pulses leave ld_words_o and memory unchanged.
REQ-036 With DEPTH_WORDS=4, stream 17 bytes with no ld_last_i -> 16 bytes are written, the 17th causes ld_err_o=1, ld_ready_o=0 and core_rst_o=0 held until reset.
REQ-037 Assert rst_i=0 asynchronously after 5 bytes of a load, then reload the 4-byte image 13 00 00 00 -> ld_words_o=1, and fetch at 0x0 with rom_ce_i=1 returns 32'h00000013.
REQ-038 In RUN, drive rom_ce_i=0 at address 0x0 -> rom_data_o=NOP_INST; drive address 0x3 -> same word as address 0x0.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader; holds the core in reset until the image is in, then serves zero-latency fetches.
// ld_ready_o is high in IDLE/LOAD and low in RUN/ERR; fetch data is combinational from the address.
module imem_loader #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] NOP_INST    = 32'h00000013
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          rom_ce_i,
   input  logic [31:0]                   rom_addr_i,
   output logic [31:0]                   rom_data_o,
   input  logic                          ld_valid_i,
   input  logic [7:0]                    ld_byte_i,
   input  logic                          ld_last_i,
   output logic                          ld_ready_o,
   output logic                          core_rst_o,
   output logic                          ld_err_o,
   output logic [$clog2(DEPTH_WORDS):0]  ld_words_o
);

   localparam int AW = $clog2(DEPTH_WORDS);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_ERR  = 2'd3;

   logic [1:0]  state;
   logic [1:0]  lane;
   logic [AW:0] wptr;
   logic [31:0] word_buf;
   logic [31:0] word_nxt;
   logic [31:0] mem [DEPTH_WORDS];

   logic        accept;
   logic        full;
   logic        wr_en;
   logic        fetch_hit;
   logic [29:0] fetch_idx;
   logic        unused_addr_lsb;

   assign ld_ready_o = (state == ST_IDLE) || (state == ST_LOAD);
   assign core_rst_o = (state == ST_RUN);
   assign ld_err_o   = (state == ST_ERR);
   assign ld_words_o = wptr;

   assign accept = ld_valid_i & ld_ready_o;
   assign full   = (wptr == (AW+1)'(DEPTH_WORDS));
   // A word is committed when its top lane fills or the image ends early.
   assign wr_en  = accept & ~full & (ld_last_i | (lane == 2'd3));

   always_comb begin
      word_nxt = word_buf;
      word_nxt[{lane, 3'b000} +: 8] = ld_byte_i;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= ST_IDLE;
         lane     <= 2'd0;
         wptr     <= '0;
         word_buf <= '0;
      end else if (accept) begin
         if (full) begin
            state <= ST_ERR;
         end else begin
            if (wr_en) begin
               wptr     <= wptr + 1'b1;
               word_buf <= '0;
               lane     <= 2'd0;
            end else begin
               word_buf <= word_nxt;
               lane     <= lane + 2'd1;
            end
            state <= ld_last_i ? ST_RUN : ST_LOAD;
         end
      end
   end

   // Memory is deliberately left uninitialised across resets; wptr bounds what is visible.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[wptr[AW-1:0]] <= word_nxt;
      end
   end

   assign fetch_idx       = rom_addr_i[31:2];
   assign unused_addr_lsb = ^rom_addr_i[1:0];
   assign fetch_hit       = (state == ST_RUN) && rom_ce_i && (fetch_idx < 30'(wptr));
   assign rom_data_o      = fetch_hit ? mem[rom_addr_i[AW+1:2]] : NOP_INST;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader against a byte-image reference model.
module tb_imem_loader;

   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h00000013;

   typedef logic [7:0] byte_q_t[$];

   logic        clk_i;
   logic        rst_i;
   logic        rom_ce_i;
   logic [31:0] rom_addr_i;
   logic [31:0] rom_data_o;
   logic        ld_valid_i;
   logic [7:0]  ld_byte_i;
   logic        ld_last_i;
   logic        ld_ready_o;
   logic        core_rst_o;
   logic        ld_err_o;
   logic [2:0]  ld_words_o;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] exp_mem [DEPTH];
   int          exp_words;
   bit          exp_run;
   bit          exp_err;

   imem_loader #(.DEPTH_WORDS(DEPTH), .NOP_INST(NOP)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .rom_ce_i   (rom_ce_i),
      .rom_addr_i (rom_addr_i),
      .rom_data_o (rom_data_o),
      .ld_valid_i (ld_valid_i),
      .ld_byte_i  (ld_byte_i),
      .ld_last_i  (ld_last_i),
      .ld_ready_o (ld_ready_o),
      .core_rst_o (core_rst_o),
      .ld_err_o   (ld_err_o),
      .ld_words_o (ld_words_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Model: an image of n bytes with last on its final byte either fits (ceil(n/4) words, RUN)
   // or overflows on byte 4*DEPTH+1 (DEPTH words, ERR).
   task automatic model_image(input byte_q_t img);
      int n;
      int kept;
      n       = img.size();
      exp_err = (n > 4*DEPTH);
      exp_run = !exp_err;
      exp_words = exp_err ? DEPTH : (n + 3) / 4;
      kept    = exp_err ? 4*DEPTH : n;
      for (int i = 0; i < kept; i++) begin
         if (i % 4 == 0) exp_mem[i/4] = 32'h0;
         exp_mem[i/4][8*(i%4) +: 8] = img[i];
      end
   endtask

   function automatic logic [31:0] exp_fetch(input logic [31:0] a, input logic ce);
      int w;
      w = int'(a[31:2]);
      if (exp_run && ce && (w < exp_words)) return exp_mem[w];
      return NOP;
   endfunction

   task automatic apply_reset();
      rst_i = 1'b0;
      #3;
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      exp_words = 0;
      exp_run   = 1'b0;
      exp_err   = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
      repeat (gap) begin
         ld_valid_i = 1'b0;
         ld_byte_i  = 8'($urandom);
         ld_last_i  = 1'($urandom);
         @(posedge clk_i);
         #1;
      end
      ld_valid_i = 1'b1;
      ld_byte_i  = b;
      ld_last_i  = last;
      @(posedge clk_i);
      #1;
      ld_valid_i = 1'b0;
      ld_last_i  = 1'b0;
   endtask

   task automatic load_image(input byte_q_t img, input int max_gap);
      for (int i = 0; i < img.size(); i++)
         send_byte(img[i], i == img.size() - 1, $urandom_range(0, max_gap));
      model_image(img);
   endtask

   task automatic fetch(input logic [31:0] a, input logic ce);
      @(negedge clk_i);
      rom_addr_i = a;
      rom_ce_i   = ce;
      #1;
   endtask

   task automatic test_reset();
      #2;
      n_cmp++; if (ld_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b want=1", ld_ready_o); end
      n_cmp++; if (core_rst_o !== 1'b0) begin n_err++; $display("FAIL reset_core_rst got=%b want=0", core_rst_o); end
      n_cmp++; if (ld_err_o !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b want=0", ld_err_o); end
      n_cmp++; if (ld_words_o !== 3'd0) begin n_err++; $display("FAIL reset_words got=%0d want=0", ld_words_o); end
      fetch(32'h0, 1'b1);
      n_cmp++; if (rom_data_o !== NOP) begin n_err++; $display("FAIL reset_fetch got=%h want=%h", rom_data_o, NOP); end
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_basic_image();
      byte_q_t img;
      img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      load_image(img, 0);
      n_cmp++; if (ld_words_o !== 3'd2) begin n_err++; $display("FAIL basic_words got=%0d want=2", ld_words_o); end
      n_cmp++; if (core_rst_o !== 1'b1) begin n_err++; $display("FAIL basic_core_rst got=%b want=1", core_rst_o); end
      n_cmp++; if (ld_ready_o !== 1'b0) begin n_err++; $display("FAIL basic_ready got=%b want=0", ld_ready_o); end
      fetch(32'h4, 1'b1);
      n_cmp++; if (rom_data_o !== 32'h00100093) begin n_err++; $display("FAIL basic_fetch4 got=%h want=00100093", rom_data_o); end
      fetch(32'h8, 1'b1);
      n_cmp++; if (rom_data_o !== NOP) begin n_err++; $display("FAIL basic_fetch8 got=%h want=%h", rom_data_o, NOP); end
   endtask

   task automatic test_partial_word();
      byte_q_t img;
      apply_reset();
      img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
      load_image(img, 1);
      n_cmp++; if (ld_words_o !== 3'd2) begin n_err++; $display("FAIL partial_words got=%0d want=2", ld_words_o); end
      fetch(32'h0, 1'b1);
      n_cmp++; if (rom_data_o !== 32'hDDCCBBAA) begin n_err++; $display("FAIL partial_fetch0 got=%h want=ddccbbaa", rom_data_o); end
      fetch(32'h4, 1'b1);
      n_cmp++; if (rom_data_o !== 32'h00002211) begin n_err++; $display("FAIL partial_fetch4 got=%h want=00002211", rom_data_o); end
      fetch(32'h8, 1'b1);
      n_cmp++; if (rom_data_o !== NOP) begin n_err++; $display("FAIL partial_fetch8 got=%h want=%h", rom_data_o, NOP); end
   endtask

   task automatic test_gaps_and_run_ignore();
      byte_q_t img;
      logic [31:0] a;
      apply_reset();
      img = {};
      repeat ($urandom_range(5, 14)) img.push_back(8'($urandom));
      load_image(img, 3);
      n_cmp++; if (ld_words_o !== 3'(exp_words)) begin n_err++; $display("FAIL gaps_words got=%0d want=%0d", ld_words_o, exp_words); end
      repeat (6) send_byte(8'($urandom), 1'($urandom), $urandom_range(0, 2));
      n_cmp++; if (ld_words_o !== 3'(exp_words)) begin n_err++; $display("FAIL run_ignore_words got=%0d want=%0d", ld_words_o, exp_words); end
      n_cmp++; if (core_rst_o !== 1'b1) begin n_err++; $display("FAIL run_ignore_core_rst got=%b want=1", core_rst_o); end
      for (int w = 0; w < DEPTH; w++) begin
         a = {30'(w), 2'($urandom)};
         fetch(a, 1'b1);
         n_cmp++; if (rom_data_o !== exp_fetch(a, 1'b1)) begin n_err++; $display("FAIL run_ignore_fetch addr=%h got=%h want=%h", a, rom_data_o, exp_fetch(a, 1'b1)); end
      end
   endtask

   task automatic test_overflow();
      apply_reset();
      for (int i = 0; i < 4*DEPTH; i++) send_byte(8'($urandom), 1'b0, 0);
      n_cmp++; if (ld_words_o !== 3'(DEPTH)) begin n_err++; $display("FAIL ovf_full_words got=%0d want=%0d", ld_words_o, DEPTH); end
      n_cmp++; if (ld_ready_o !== 1'b1) begin n_err++; $display("FAIL ovf_full_ready got=%b want=1", ld_ready_o); end
      send_byte(8'($urandom), 1'b0, 0);
      n_cmp++; if (ld_err_o !== 1'b1) begin n_err++; $display("FAIL ovf_err got=%b want=1", ld_err_o); end
      n_cmp++; if (ld_ready_o !== 1'b0) begin n_err++; $display("FAIL ovf_ready got=%b want=0", ld_ready_o); end
      n_cmp++; if (core_rst_o !== 1'b0) begin n_err++; $display("FAIL ovf_core_rst got=%b want=0", core_rst_o); end
      repeat (3) send_byte(8'($urandom), 1'b1, 2);
      n_cmp++; if (ld_err_o !== 1'b1 || core_rst_o !== 1'b0) begin n_err++; $display("FAIL ovf_hold err=%b core_rst=%b want err=1 core_rst=0", ld_err_o, core_rst_o); end
      n_cmp++; if (ld_words_o !== 3'(DEPTH)) begin n_err++; $display("FAIL ovf_hold_words got=%0d want=%0d", ld_words_o, DEPTH); end
      fetch(32'h0, 1'b1);
      n_cmp++; if (rom_data_o !== NOP) begin n_err++; $display("FAIL ovf_fetch got=%h want=%h", rom_data_o, NOP); end
      apply_reset();
      n_cmp++; if (ld_err_o !== 1'b0 || ld_ready_o !== 1'b1) begin n_err++; $display("FAIL ovf_cleared err=%b ready=%b want err=0 ready=1", ld_err_o, ld_ready_o); end
   endtask

   task automatic test_midload_reset();
      byte_q_t img;
      apply_reset();
      img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      for (int i = 0; i < 5; i++) send_byte(img[i], 1'b0, 0);
      #2;
      rst_i = 1'b0;
      #1;
      n_cmp++; if (ld_words_o !== 3'd0) begin n_err++; $display("FAIL midrst_words got=%0d want=0", ld_words_o); end
      n_cmp++; if (ld_ready_o !== 1'b1 || core_rst_o !== 1'b0 || ld_err_o !== 1'b0) begin n_err++; $display("FAIL midrst_flags ready=%b core_rst=%b err=%b want 1 0 0", ld_ready_o, core_rst_o, ld_err_o); end
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      img = '{8'h13, 8'h00, 8'h00, 8'h00};
      load_image(img, 0);
      n_cmp++; if (ld_words_o !== 3'd1) begin n_err++; $display("FAIL midrst_reload_words got=%0d want=1", ld_words_o); end
      fetch(32'h0, 1'b1);
      n_cmp++; if (rom_data_o !== 32'h00000013) begin n_err++; $display("FAIL midrst_fetch0 got=%h want=00000013", rom_data_o); end
      fetch(32'h4, 1'b1);
      n_cmp++; if (rom_data_o !== NOP) begin n_err++; $display("FAIL midrst_fetch4 got=%h want=%h", rom_data_o, NOP); end
   endtask

   task automatic test_fetch_ce();
      byte_q_t img;
      apply_reset();
      img = {};
      repeat (8) img.push_back(8'($urandom));
      img[0] = 8'hA5;
      load_image(img, 0);
      fetch(32'h0, 1'b0);
      n_cmp++; if (rom_data_o !== NOP) begin n_err++; $display("FAIL ce_off got=%h want=%h", rom_data_o, NOP); end
      for (int b = 0; b < 4; b++) begin
         fetch(32'(b), 1'b1);
         n_cmp++; if (rom_data_o !== exp_mem[0]) begin n_err++; $display("FAIL ce_lsb%0d got=%h want=%h", b, rom_data_o, exp_mem[0]); end
      end
      fetch(32'h7, 1'b1);
      n_cmp++; if (rom_data_o !== exp_mem[1]) begin n_err++; $display("FAIL ce_addr7 got=%h want=%h", rom_data_o, exp_mem[1]); end
   endtask

   task automatic test_random();
      byte_q_t img;
      logic [31:0] a;
      logic ce;
      for (int it = 0; it < 10; it++) begin
         apply_reset();
         img = {};
         repeat ($urandom_range(1, 4*DEPTH + 3)) img.push_back(8'($urandom));
         load_image(img, 2);
         n_cmp++; if (ld_words_o !== 3'(exp_words)) begin n_err++; $display("FAIL rand%0d_words got=%0d want=%0d", it, ld_words_o, exp_words); end
         n_cmp++; if (ld_err_o !== exp_err || core_rst_o !== exp_run || ld_ready_o !== 1'b0) begin n_err++; $display("FAIL rand%0d_flags err=%b core_rst=%b ready=%b want %b %b 0", it, ld_err_o, core_rst_o, ld_ready_o, exp_err, exp_run); end
         for (int w = 0; w <= DEPTH; w++) begin
            a  = {30'(w), 2'($urandom)};
            ce = ($urandom_range(0, 3) != 0);
            fetch(a, ce);
            n_cmp++; if (rom_data_o !== exp_fetch(a, ce)) begin n_err++; $display("FAIL rand%0d_fetch addr=%h ce=%b got=%h want=%h", it, a, ce, rom_data_o, exp_fetch(a, ce)); end
         end
         a = $urandom | 32'h8000_0000;
         fetch(a, 1'b1);
         n_cmp++; if (rom_data_o !== NOP) begin n_err++; $display("FAIL rand%0d_high addr=%h got=%h want=%h", it, a, rom_data_o, NOP); end
      end
   endtask

   initial begin
      rst_i      = 1'b0;
      rom_ce_i   = 1'b0;
      rom_addr_i = 32'h0;
      ld_valid_i = 1'b0;
      ld_byte_i  = 8'h0;
      ld_last_i  = 1'b0;
      exp_words  = 0;
      exp_run    = 1'b0;
      exp_err    = 1'b0;
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;

      test_reset();
      test_basic_image();
      test_partial_word();
      test_gaps_and_run_ignore();
      test_overflow();
      test_midload_reset();
      test_fetch_ce();
      test_random();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
